// File: rtl/seg_pkg.sv
// Shared types and default constants for the seg_scan display scanner.
`timescale 1ns/1ps
package seg_pkg;

    typedef enum logic {
        SCAN_GUARD = 1'b0,
        SCAN_SHOW  = 1'b1
    } seg_scan_state_t;

    localparam int SEG_DIGITS_DEF      = 4;
    localparam int SEG_REFRESH_DIV_DEF = 100000;
    localparam int SEG_GUARD_DEF       = 1000;

    // Digit index width; a single-digit bank still needs one bit.
    function automatic int seg_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_refresh_tick.sv
// Slot counter for seg_scan: counts 0..REFRESH_DIV-1 and flags slot start,
// end of the anode-off guard window, and the last count before the wrap.
`timescale 1ns/1ps
module seg_refresh_tick
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = SEG_REFRESH_DIV_DEF,
    parameter int GUARD_CYCLES = SEG_GUARD_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic slot_start,
    output logic guard_done,
    output logic slot_last
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD_CYCLES);
    localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign slot_start = (cnt_q == '0);
    assign guard_done = (cnt_q == GUARD_CNT);
    assign slot_last  = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = slot_last ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered data.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_SUPPRESS_EN.
`timescale 1ns/1ps
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = SEG_DIGITS_DEF,
    parameter int REFRESH_DIV  = SEG_REFRESH_DIV_DEF,
    parameter int GUARD_CYCLES = SEG_GUARD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [3:0]              display_data,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int IW = seg_idx_width(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    logic                    slot_start;
    logic                    guard_done;
    logic                    slot_last;

    logic [4*NUM_DIGITS-1:0] pend_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic [4*NUM_DIGITS-1:0] act_val_q;
    logic [NUM_DIGITS-1:0]   act_dp_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    seg_scan_state_t         state_q;

    logic [NUM_DIGITS-1:0]   anode_n_q;
    logic [3:0]              data_q;
    logic                    dp_n_q;
    logic                    frame_start_q;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   cur_sel;
    logic [NUM_DIGITS-1:0]   lz_keep;
    logic [NUM_DIGITS-1:0]   digit_on;
    logic                    frame_end;

    seg_refresh_tick #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .slot_start (slot_start),
        .guard_done (guard_done),
        .slot_last  (slot_last)
    );

    assign frame_end = slot_last && (idx_q == LAST_IDX);

    always_comb begin
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib    = act_val_q[4*i +: 4];
                cur_dp     = act_dp_q[i];
                cur_sel[i] = 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    // A digit stays lit only if it or some more-significant nibble is nonzero.
    logic any_nz;
    always_comb begin
        lz_keep    = '0;
        any_nz     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            any_nz     = any_nz | (act_val_q[4*i +: 4] != 4'h0);
            lz_keep[i] = any_nz;
        end
        lz_keep[0] = 1'b1;
    end
`else
    assign lz_keep = '1;
`endif

    assign digit_on = digit_en & lz_keep;

    // NOTE: the display buffers are small registers, not a RAM, so they take
    // the async reset and start blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            idx_q      <= '0;
        end else begin
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp;
            end
            // Swap only at the frame wrap so a frame never mixes old and new data.
            if (frame_end) begin
                act_val_q <= pend_val_q;
                act_dp_q  <= pend_dp_q;
            end
            if (slot_last) begin
                idx_q <= idx_d;
            end
        end
    end

    // Scan FSM with registered outputs; anode enables are refreshed every
    // SHOW cycle so digit_en changes land one cycle later even mid-slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SCAN_GUARD;
            anode_n_q     <= '1;
            data_q        <= 4'h0;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else if (slot_start) begin
            state_q       <= SCAN_GUARD;
            anode_n_q     <= '1;
            data_q        <= cur_nib;
            dp_n_q        <= ~cur_dp;
            frame_start_q <= (idx_q == '0);
        end else begin
            frame_start_q <= 1'b0;
            if (guard_done || state_q == SCAN_SHOW) begin
                state_q   <= SCAN_SHOW;
                anode_n_q <= ~(cur_sel & digit_on);
            end else begin
                state_q   <= SCAN_GUARD;
                anode_n_q <= '1;
            end
        end
    end

    assign anode_n      = anode_n_q;
    assign display_data = data_q;
    assign dp_n         = dp_n_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
`timescale 1ns/1ps
module tb_seg_scan;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value = '0;
    logic          load = 1'b0;
    logic [ND-1:0] dp = '0;
    logic [ND-1:0] digit_en = '1;
    logic [ND-1:0] anode_n;
    logic [3:0]    display_data;
    logic          dp_n;
    logic          frame_start;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int       edge_no;
        logic [3:0] an;
        logic [3:0] data;
        logic       dpn;
        logic       fs;
    } vec_t;

    vec_t vecs[18];

    seg_scan #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .value        (value),
        .load         (load),
        .dp           (dp),
        .digit_en     (digit_en),
        .anode_n      (anode_n),
        .display_data (display_data),
        .dp_n         (dp_n),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Packs {anode_n, display_data, dp_n, frame_start} into one compare.
    task automatic check_out(input string name, input logic [3:0] an, input logic [3:0] data,
                             input logic dpn, input logic fs);
        check(name, {22'd0, anode_n, display_data, dp_n, frame_start},
                    {22'd0, an, data, dpn, fs});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_edge(input int e);
        while (cyc < e) step();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        digit_en = '1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 4'b1111, 4'h0, 1'b1, 1'b0);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Drives a one-cycle load strobe that is captured on edge e.
    task automatic load_at(input int e, input logic [15:0] v, input logic [3:0] d);
        goto_edge(e - 1);
        value = v;
        dp    = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        // Frame 0 shows the blank active buffer; frame 1 shows 1A3F with dp on digit 2.
        vecs[0]  = '{1,  4'b1111, 4'h0, 1'b1, 1'b1};
        vecs[1]  = '{2,  4'b1111, 4'h0, 1'b1, 1'b0};
        vecs[2]  = '{3,  4'b1110, 4'h0, 1'b1, 1'b0};
        vecs[3]  = '{8,  4'b1110, 4'h0, 1'b1, 1'b0};
        vecs[4]  = '{9,  4'b1111, 4'h0, 1'b1, 1'b0};
        vecs[5]  = '{11, 4'b1101, 4'h0, 1'b1, 1'b0};
        vecs[6]  = '{33, 4'b1111, 4'hF, 1'b1, 1'b1};
        vecs[7]  = '{34, 4'b1111, 4'hF, 1'b1, 1'b0};
        vecs[8]  = '{35, 4'b1110, 4'hF, 1'b1, 1'b0};
        vecs[9]  = '{40, 4'b1110, 4'hF, 1'b1, 1'b0};
        vecs[10] = '{41, 4'b1111, 4'h3, 1'b1, 1'b0};
        vecs[11] = '{42, 4'b1111, 4'h3, 1'b1, 1'b0};
        vecs[12] = '{43, 4'b1101, 4'h3, 1'b1, 1'b0};
        vecs[13] = '{49, 4'b1111, 4'hA, 1'b0, 1'b0};
        vecs[14] = '{51, 4'b1011, 4'hA, 1'b0, 1'b0};
        vecs[15] = '{59, 4'b0111, 4'h1, 1'b1, 1'b0};
        vecs[16] = '{64, 4'b0111, 4'h1, 1'b1, 1'b0};
        vecs[17] = '{65, 4'b1111, 4'hF, 1'b1, 1'b1};

        // Basic frame with 1A3F.
        do_reset();
        load_at(1, 16'h1A3F, 4'b0100);
        for (int i = 0; i < 18; i++) begin
            goto_edge(vecs[i].edge_no);
            check_out($sformatf("s1_e%0d", vecs[i].edge_no),
                      vecs[i].an, vecs[i].data, vecs[i].dpn, vecs[i].fs);
        end

        // Second load mid-frame must not tear the frame being displayed.
        do_reset();
        load_at(1, 16'h1234, 4'b0000);
        goto_edge(43);
        check_out("s2_old_d1", 4'b1101, 4'h3, 1'b1, 1'b0);
        load_at(52, 16'h5678, 4'b0000);
        goto_edge(59);
        check_out("s2_old_d3", 4'b0111, 4'h1, 1'b1, 1'b0);
        goto_edge(65);
        check_out("s2_new_d0", 4'b1111, 4'h8, 1'b1, 1'b1);
        goto_edge(75);
        check_out("s2_new_d1", 4'b1101, 4'h7, 1'b1, 1'b0);
        goto_edge(83);
        check_out("s2_new_d2", 4'b1011, 4'h6, 1'b1, 1'b0);
        goto_edge(91);
        check_out("s2_new_d3", 4'b0111, 4'h5, 1'b1, 1'b0);

        // Load on the frame-boundary edge lands one frame late.
        do_reset();
        load_at(1, 16'h4321, 4'b0000);
        load_at(32, 16'h8765, 4'b0000);
        goto_edge(33);
        check_out("s3_prev_d0", 4'b1111, 4'h1, 1'b1, 1'b1);
        goto_edge(59);
        check_out("s3_prev_d3", 4'b0111, 4'h4, 1'b1, 1'b0);
        goto_edge(65);
        check_out("s3_new_d0", 4'b1111, 4'h5, 1'b1, 1'b1);
        goto_edge(91);
        check_out("s3_new_d3", 4'b0111, 4'h8, 1'b1, 1'b0);

        // digit_en=1011 keeps digit 2 dark for a whole frame.
        do_reset();
        digit_en = 4'b1011;
        for (int k = 1; k <= 32; k++) begin
            int c;
            int s;
            logic [3:0] exp_an;
            goto_edge(k);
            c = (k - 1) % RD;
            s = (k - 1) / RD;
            exp_an = 4'b1111;
            if (c >= GC && s != 2) exp_an[s] = 1'b0;
            check($sformatf("s4_an_e%0d", k), {28'd0, anode_n}, {28'd0, exp_an});
        end
        // Mid-slot disable and re-enable of digit 0.
        goto_edge(36);
        digit_en = 4'b1010;
        step();
        check("s4_midslot_off", {28'd0, anode_n}, {28'd0, 4'b1111});
        digit_en = 4'b1011;
        step();
        check("s4_midslot_on", {28'd0, anode_n}, {28'd0, 4'b1110});

        // Reset asserted in the middle of digit 2's SHOW window.
        do_reset();
        goto_edge(20);
        check("s5_pre_rst", {28'd0, anode_n}, {28'd0, 4'b1011});
        rst = 1'b1;
        #1;
        check("s5_async_off", {28'd0, anode_n}, {28'd0, 4'b1111});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        step();
        check_out("s5_fs", 4'b1111, 4'h0, 1'b1, 1'b1);
        step();
        check_out("s5_guard", 4'b1111, 4'h0, 1'b1, 1'b0);
        step();
        check_out("s5_show", 4'b1110, 4'h0, 1'b1, 1'b0);

        // Leading-zero handling for 0050.
        do_reset();
        load_at(1, 16'h0050, 4'b0000);
        goto_edge(35);
        check_out("s6_d0", 4'b1110, 4'h0, 1'b1, 1'b0);
        goto_edge(43);
        check_out("s6_d1", 4'b1101, 4'h5, 1'b1, 1'b0);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        goto_edge(51);
        check_out("s6_d2", 4'b1111, 4'h0, 1'b1, 1'b0);
        goto_edge(59);
        check_out("s6_d3", 4'b1111, 4'h0, 1'b1, 1'b0);
`else
        goto_edge(51);
        check_out("s6_d2", 4'b1011, 4'h0, 1'b1, 1'b0);
        goto_edge(59);
        check_out("s6_d3", 4'b0111, 4'h0, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
